ti_cic_interp_4lane: RTL and testbench

- Transmit-side counterpart of the time-interleaved CIC decimator.
- Takes low-rate signed samples and interpolates them by R=8 with a 2-stage CIC (N=2, M=1).
- Distributes the high-rate output stream round-robin across 4 interleaved DAC lanes, presented as a parallel 4-sample word.
- Single clock domain, high-rate clock; the input side uses a valid/ready handshake.

---
 rtl/ti_cic_interp_4lane_if.sv | 25 ++
 rtl/ti_cic_interp_4lane.sv | 89 ++++++++
 tb/tb_ti_cic_interp_4lane.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ti_cic_interp_4lane_if.sv
// Sample-in / 4-lane-word-out bundle for the interleaved CIC interpolator.
// master drives samples and consumes words; slave is the interpolator.
interface ti_cic_interp_4lane_if #(
  parameter int BW = 11
);
  logic signed [BW-1:0] IN;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic signed [BW+2:0] OUT1;
  logic signed [BW+2:0] OUT2;
  logic signed [BW+2:0] OUT3;
  logic signed [BW+2:0] OUT4;
  logic                 OUT_VALID;
  logic                 UNDERFLOW;

  modport master (
    output IN, IN_VALID,
    input  IN_READY, OUT1, OUT2, OUT3, OUT4, OUT_VALID, UNDERFLOW
  );

  modport slave (
    input  IN, IN_VALID,
    output IN_READY, OUT1, OUT2, OUT3, OUT4, OUT_VALID, UNDERFLOW
  );
endinterface

// File: rtl/ti_cic_interp_4lane.sv
// R=8, N=2 CIC interpolator packing the high-rate stream into 4-sample DAC words.
// Input sample first reaches i2 two edges after accept; word registered 1 clk after its last sample; a missing sample is held (sticky UNDERFLOW).
module ti_cic_interp_4lane #(
  parameter int BW = 11
) (
  input  logic                        CLK,
  input  logic                        RES,
  input  logic                        ENABLE,
  ti_cic_interp_4lane_if.slave        bus
);
  localparam int W = BW + 3;

  logic [2:0]          phase;
  logic [1:0]          lane;
  logic signed [W-1:0] x_d;
  logic signed [W-1:0] c1_d;
  logic signed [W-1:0] s;
  logic signed [W-1:0] i1;
  logic signed [W-1:0] i2;
  logic signed [W-1:0] lane_buf [3];
  logic signed [W-1:0] out1, out2, out3, out4;
  logic                out_vld;
  logic                underflow;

  logic signed [W-1:0] x;
  logic signed [W-1:0] c1;
  logic signed [W-1:0] c2;

  // A missing sample repeats the previous one so the output holds its level.
  always_comb begin
    x  = bus.IN_VALID ? {{3{bus.IN[BW-1]}}, bus.IN} : x_d;
    c1 = x - x_d;
    c2 = c1 - c1_d;
  end

  assign bus.IN_READY  = ENABLE & (phase == 3'd0);
  assign bus.OUT1      = out1;
  assign bus.OUT2      = out2;
  assign bus.OUT3      = out3;
  assign bus.OUT4      = out4;
  assign bus.OUT_VALID = out_vld & ENABLE;
  assign bus.UNDERFLOW = underflow;

  always_ff @(posedge CLK) begin
    if (RES) begin
      phase     <= '0;
      lane      <= '0;
      x_d       <= '0;
      c1_d      <= '0;
      s         <= '0;
      i1        <= '0;
      i2        <= '0;
      for (int k = 0; k < 3; k++) lane_buf[k] <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out4      <= '0;
      out_vld   <= 1'b0;
      underflow <= 1'b0;
    end else if (ENABLE) begin
      phase <= phase + 3'd1;
      lane  <= lane + 2'd1;

      if (phase == 3'd0) begin
        x_d  <= x;
        c1_d <= c1;
        s    <= c2;
        if (!bus.IN_VALID) underflow <= 1'b1;
      end else begin
        s <= '0;
      end

      // Integrators see the comb output of the previous edge (old s).
      i1 <= i1 + s;
      i2 <= i2 + i1;

      if (lane == 2'd3) begin
        out1    <= lane_buf[0];
        out2    <= lane_buf[1];
        out3    <= lane_buf[2];
        out4    <= i2;
        out_vld <= 1'b1;
      end else begin
        lane_buf[lane] <= i2;
        out_vld        <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ti_cic_interp_4lane.sv
// Directed self-checking bench for ti_cic_interp_4lane.
module tb_ti_cic_interp_4lane;
  logic clk;
  logic res;
  logic enable;
  int   vec;
  int   errs;

  ti_cic_interp_4lane_if #(.BW(11)) bus ();

  ti_cic_interp_4lane #(.BW(11)) dut (
    .CLK    (clk),
    .RES    (res),
    .ENABLE (enable),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    step();
    res = 1'b0;
  endtask

  task automatic get_word(output int w1, output int w2, output int w3, output int w4);
    bit got;
    got = 1'b0;
    w1 = 0; w2 = 0; w3 = 0; w4 = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (bus.OUT_VALID === 1'b1) begin
        got = 1'b1;
        w1 = int'(bus.OUT1);
        w2 = int'(bus.OUT2);
        w3 = int'(bus.OUT3);
        w4 = int'(bus.OUT4);
      end
    end
    if (!got) begin
      vec++;
      errs++;
      $display("FAIL word_timeout: no OUT_VALID within 20 cycles, required a strobe");
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    bus.IN = '0;
    bus.IN_VALID = 1'b0;
    do_reset();
    vec++;
    if (bus.OUT1 !== 14'd0 || bus.OUT2 !== 14'd0 || bus.OUT3 !== 14'd0 || bus.OUT4 !== 14'd0) begin
      errs++;
      $display("FAIL reset_outs: got %0d %0d %0d %0d, required 0 0 0 0",
               bus.OUT1, bus.OUT2, bus.OUT3, bus.OUT4);
    end
    vec++;
    if (bus.OUT_VALID !== 1'b0 || bus.UNDERFLOW !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: OUT_VALID=%b UNDERFLOW=%b, required 0 0", bus.OUT_VALID, bus.UNDERFLOW);
    end
    vec++;
    if (bus.IN_READY !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready: IN_READY=%b, required 1", bus.IN_READY);
    end
  endtask

  task automatic test_step();
    int exp_y [16] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8, 8, 8};
    int wi;
    wi = 0;
    enable = 1'b1;
    bus.IN = 11'sd1;
    bus.IN_VALID = 1'b1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      vec++;
      if (bus.IN_READY !== (c % 8 == 0)) begin
        errs++;
        $display("FAIL step_ready c=%0d: IN_READY=%b, required %b", c, bus.IN_READY, (c % 8 == 0));
      end
      step();
      if (bus.OUT_VALID === 1'b1) begin
        if (wi < 4) begin
          vec++;
          if (int'(bus.OUT1) !== exp_y[4*wi] || int'(bus.OUT2) !== exp_y[4*wi+1] ||
              int'(bus.OUT3) !== exp_y[4*wi+2] || int'(bus.OUT4) !== exp_y[4*wi+3]) begin
            errs++;
            $display("FAIL step_word%0d: got %0d %0d %0d %0d, required %0d %0d %0d %0d", wi,
                     bus.OUT1, bus.OUT2, bus.OUT3, bus.OUT4,
                     exp_y[4*wi], exp_y[4*wi+1], exp_y[4*wi+2], exp_y[4*wi+3]);
          end
        end
        wi++;
      end
    end
    vec++;
    if (wi != 4) begin
      errs++;
      $display("FAIL step_word_count: got %0d strobes, required 4", wi);
    end
    vec++;
    if (bus.UNDERFLOW !== 1'b0) begin
      errs++;
      $display("FAIL step_underflow: UNDERFLOW=%b, required 0", bus.UNDERFLOW);
    end
  endtask

  task automatic test_extremes();
    int w1, w2, w3, w4;
    enable = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN = 11'sd1023;
    do_reset();
    repeat (160) step();
    get_word(w1, w2, w3, w4);
    vec++;
    if (w1 !== 8184 || w2 !== 8184 || w3 !== 8184 || w4 !== 8184) begin
      errs++;
      $display("FAIL max_steady: got %0d %0d %0d %0d, required 8184 x4", w1, w2, w3, w4);
    end
    bus.IN = 11'h400;
    repeat (160) step();
    get_word(w1, w2, w3, w4);
    vec++;
    if (w1 !== -8192 || w2 !== -8192 || w3 !== -8192 || w4 !== -8192) begin
      errs++;
      $display("FAIL min_steady: got %0d %0d %0d %0d, required -8192 x4", w1, w2, w3, w4);
    end
  endtask

  task automatic test_impulse();
    int w1, w2, w3, w4;
    int sum;
    int peak;
    sum = 0;
    peak = 0;
    enable = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN = 11'sd4;
    do_reset();
    step();
    bus.IN = 11'sd0;
    for (int m = 0; m < 6; m++) begin
      get_word(w1, w2, w3, w4);
      sum += w1 + w2 + w3 + w4;
      if (w1 > peak) peak = w1;
      if (w2 > peak) peak = w2;
      if (w3 > peak) peak = w3;
      if (w4 > peak) peak = w4;
      if (m == 2) begin
        vec++;
        if (w1 !== 24 || w2 !== 28 || w3 !== 32 || w4 !== 28) begin
          errs++;
          $display("FAIL impulse_peak_word: got %0d %0d %0d %0d, required 24 28 32 28", w1, w2, w3, w4);
        end
      end
      if (m == 5) begin
        vec++;
        if (w1 !== 0 || w2 !== 0 || w3 !== 0 || w4 !== 0) begin
          errs++;
          $display("FAIL impulse_tail: got %0d %0d %0d %0d, required 0 0 0 0", w1, w2, w3, w4);
        end
      end
    end
    vec++;
    if (sum !== 256) begin
      errs++;
      $display("FAIL impulse_sum: got %0d, required 256", sum);
    end
    vec++;
    if (peak !== 32) begin
      errs++;
      $display("FAIL impulse_max: got %0d, required 32", peak);
    end
  endtask

  task automatic test_underflow();
    int w1, w2, w3, w4;
    enable = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN = 11'sd5;
    do_reset();
    repeat (8) step();
    vec++;
    if (bus.UNDERFLOW !== 1'b0 || bus.IN_READY !== 1'b1) begin
      errs++;
      $display("FAIL uf_before: UNDERFLOW=%b IN_READY=%b, required 0 1", bus.UNDERFLOW, bus.IN_READY);
    end
    bus.IN_VALID = 1'b0;
    step();
    vec++;
    if (bus.UNDERFLOW !== 1'b1) begin
      errs++;
      $display("FAIL uf_rise: UNDERFLOW=%b, required 1", bus.UNDERFLOW);
    end
    bus.IN_VALID = 1'b1;
    repeat (40) step();
    get_word(w1, w2, w3, w4);
    vec++;
    if (w1 !== 40 || w2 !== 40 || w3 !== 40 || w4 !== 40) begin
      errs++;
      $display("FAIL uf_hold_level: got %0d %0d %0d %0d, required 40 x4", w1, w2, w3, w4);
    end
    vec++;
    if (bus.UNDERFLOW !== 1'b1) begin
      errs++;
      $display("FAIL uf_sticky: UNDERFLOW=%b, required 1", bus.UNDERFLOW);
    end
  endtask

  task automatic test_pause();
    int w1, w2, w3, w4;
    enable = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN = 11'sd1;
    do_reset();
    repeat (5) step();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      vec++;
      if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b0 ||
          bus.OUT1 !== 14'sd0 || bus.OUT2 !== 14'sd0 || bus.OUT3 !== 14'sd0 || bus.OUT4 !== 14'sd1) begin
        errs++;
        $display("FAIL pause_frozen c=%0d: vld=%b rdy=%b outs %0d %0d %0d %0d, required 0 0 outs 0 0 0 1",
                 c, bus.OUT_VALID, bus.IN_READY, bus.OUT1, bus.OUT2, bus.OUT3, bus.OUT4);
      end
    end
    enable = 1'b1;
    get_word(w1, w2, w3, w4);
    vec++;
    if (w1 !== 2 || w2 !== 3 || w3 !== 4 || w4 !== 5) begin
      errs++;
      $display("FAIL pause_resume_w1: got %0d %0d %0d %0d, required 2 3 4 5", w1, w2, w3, w4);
    end
    get_word(w1, w2, w3, w4);
    vec++;
    if (w1 !== 6 || w2 !== 7 || w3 !== 8 || w4 !== 8) begin
      errs++;
      $display("FAIL pause_resume_w2: got %0d %0d %0d %0d, required 6 7 8 8", w1, w2, w3, w4);
    end
  endtask

  // Runs straight after the underflow scenario so the sticky flag is set going in.
  task automatic test_reset_mid();
    int w1, w2, w3, w4;
    enable = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN = 11'sd1;
    repeat (6) step();
    res = 1'b1;
    step();
    vec++;
    if (bus.OUT1 !== 14'sd0 || bus.OUT2 !== 14'sd0 || bus.OUT3 !== 14'sd0 || bus.OUT4 !== 14'sd0 ||
        bus.OUT_VALID !== 1'b0 || bus.UNDERFLOW !== 1'b0) begin
      errs++;
      $display("FAIL midreset_clear: outs %0d %0d %0d %0d vld=%b uf=%b, required all 0",
               bus.OUT1, bus.OUT2, bus.OUT3, bus.OUT4, bus.OUT_VALID, bus.UNDERFLOW);
    end
    res = 1'b0;
    vec++;
    if (bus.IN_READY !== 1'b1) begin
      errs++;
      $display("FAIL midreset_ready: IN_READY=%b, required 1", bus.IN_READY);
    end
    step();
    vec++;
    if (bus.IN_READY !== 1'b0) begin
      errs++;
      $display("FAIL midreset_phase1: IN_READY=%b, required 0", bus.IN_READY);
    end
    get_word(w1, w2, w3, w4);
    vec++;
    if (w1 !== 0 || w2 !== 0 || w3 !== 0 || w4 !== 1) begin
      errs++;
      $display("FAIL midreset_word0: got %0d %0d %0d %0d, required 0 0 0 1", w1, w2, w3, w4);
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    res = 1'b1;
    enable = 1'b0;
    bus.IN = '0;
    bus.IN_VALID = 1'b0;
    test_reset();
    test_step();
    test_extremes();
    test_impulse();
    test_pause();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
